// File: rtl/adder_share_sched_pkg.sv
// ---------------------------------------------------------------------------
// adder_sched_pkg
// Shared constants and width helpers for the time-shared split adder
// (adder_share_sched) and its round-robin arbiter.
//   LP_LATENCY   : grant-to-result latency in clock edges (two pipeline stages)
//   clog2_min1() : ceil(log2(n)), never less than 1
//   id_width()   : width of a requester index for a given requester count
//   half_width() : width of one adder half for a given operand width
// The stage-1 record is declared in the top module because its field widths
// follow that module's parameters.
// ---------------------------------------------------------------------------
package adder_sched_pkg;

  localparam int LP_LATENCY = 2;

  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << w) < n) w = w + 1;
    end
    if (w < 1) w = 1;
    return w;
  endfunction

  function automatic int id_width(input int num_req);
    return clog2_min1(num_req);
  endfunction

  function automatic int half_width(input int data_width);
    return data_width / 2;
  endfunction

endpackage

// File: rtl/adder_share_sched_if.sv
// ---------------------------------------------------------------------------
// adder_share_sched_if
// Bundles the requester-side bus of adder_share_sched.
//   i_req   [N]     request per requester
//   i_a/i_b [N*W]   operands, requester k at [k*W +: W]
//   i_cin   [N]     carry-in per requester
//   i_hold          1 = no new grants this cycle
//   o_gnt   [N]     one-hot grant (combinational)
//   o_vld           result valid pulse
//   o_id    [ID_W]  requester index of the result
//   o_sum   [W]     a+b+cin mod 2^W
//   o_cout          carry out of the MSB
//
// Handshake: i_req[k] acts as "valid" and o_gnt[k] as "ready". An operation
// transfers on the rising clock edge where both are 1. Until that edge the
// requester keeps i_req[k], i_a, i_b and i_cin for slot k stable; afterwards
// it may drop or change them. Results have no back-pressure: the consumer
// must take o_vld/o_id/o_sum/o_cout on the cycle they are presented.
//
// master : requester/consumer side, slave : adder_share_sched.
// ---------------------------------------------------------------------------
interface adder_share_sched_if #(
  parameter int P_DATA_WIDTH = 6,
  parameter int P_NUM_REQ    = 4
);
  import adder_sched_pkg::*;

  localparam int LP_ID_W = id_width(P_NUM_REQ);

  logic [P_NUM_REQ-1:0]              i_req;
  logic [P_NUM_REQ*P_DATA_WIDTH-1:0] i_a;
  logic [P_NUM_REQ*P_DATA_WIDTH-1:0] i_b;
  logic [P_NUM_REQ-1:0]              i_cin;
  logic                              i_hold;
  logic [P_NUM_REQ-1:0]              o_gnt;
  logic                              o_vld;
  logic [LP_ID_W-1:0]                o_id;
  logic [P_DATA_WIDTH-1:0]           o_sum;
  logic                              o_cout;

  modport master (
    output i_req, i_a, i_b, i_cin, i_hold,
    input  o_gnt, o_vld, o_id, o_sum, o_cout
  );

  modport slave (
    input  i_req, i_a, i_b, i_cin, i_hold,
    output o_gnt, o_vld, o_id, o_sum, o_cout
  );

endinterface

// File: rtl/adder_share_sched_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Picks one requester per cycle for the shared adder.
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_req  [N]     requests
//   i_hold         1 = grant nothing this cycle
//   o_gnt  [N]     one-hot grant, combinational
//   o_gnt_id       index of the granted requester (0 when nothing granted)
// Round-robin: search starts at the pointer and wraps; after a grant to k the
// pointer moves to k+1 (wrapping), so the winner gets lowest priority next.
// Configuration macro ADDER_SCHED_PRIO_EN: when defined, the pointer register
// is removed and the search always starts at 0 (fixed priority, lowest index
// wins).
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int P_NUM_REQ = 4,
  parameter int P_ID_W    = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [P_NUM_REQ-1:0] i_req,
  input  logic                 i_hold,
  output logic [P_NUM_REQ-1:0] o_gnt,
  output logic [P_ID_W-1:0]    o_gnt_id
);

  logic [P_ID_W-1:0] ptr;
  logic              found;
  int                ptr_i;
  int                pos;

  // Walk the requesters in priority order ptr, ptr+1, ... and take the first
  // one asserted. Only int comparisons are used so every bit select is static.
  always_comb begin
    o_gnt    = '0;
    o_gnt_id = '0;
    found    = 1'b0;
    ptr_i    = int'(ptr);
    pos      = 0;
    if (!i_hold) begin
      for (int i = 0; i < P_NUM_REQ; i++) begin
        pos = ptr_i + i;
        if (pos >= P_NUM_REQ) pos = pos - P_NUM_REQ;
        for (int k = 0; k < P_NUM_REQ; k++) begin
          if (!found && (k == pos) && i_req[k]) begin
            found    = 1'b1;
            o_gnt[k] = 1'b1;
            o_gnt_id = P_ID_W'(k);
          end
        end
      end
    end
  end

`ifdef ADDER_SCHED_PRIO_EN
  // Fixed priority: no pointer state, clock and reset have nothing to drive.
  logic unused_clk_rst;
  assign unused_clk_rst = i_clk ^ i_rst;
  assign ptr = '0;
`else
  logic [P_ID_W-1:0] next_ptr;

  always_comb begin
    next_ptr = '0;
    if (o_gnt_id != P_ID_W'(P_NUM_REQ - 1)) next_ptr = o_gnt_id + P_ID_W'(1);
  end

  // Pointer only moves on an accepted grant, so it stays frozen under i_hold.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr <= '0;
    end else if (|o_gnt) begin
      ptr <= next_ptr;
    end
  end
`endif

endmodule

// File: rtl/adder_share_sched.sv
// ---------------------------------------------------------------------------
// adder_share_sched
// Time-shares one two-stage split adder among P_NUM_REQ requesters. The
// arbiter picks a requester, its operands are captured on the grant edge,
// the low half is added in stage 1 and the high half (with the registered
// low carry) in stage 2. The result leaves tagged with the requester index
// exactly two edges after the grant, at one op per cycle.
// Ports:
//   i_clk   rising-edge clock
//   i_rst   asynchronous active-high reset; drops all in-flight ops
//   bus     adder_share_sched_if.slave (requests, operands, grant, result)
// Parameters: P_DATA_WIDTH (even), P_NUM_REQ (>= 2).
// Configuration macro ADDER_SCHED_PRIO_EN selects fixed priority in the
// arbiter instead of round-robin.
// ---------------------------------------------------------------------------
module adder_share_sched #(
  parameter int P_DATA_WIDTH = 6,
  parameter int P_NUM_REQ    = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  adder_share_sched_if.slave  bus
);
  import adder_sched_pkg::*;

  localparam int LP_HALF = half_width(P_DATA_WIDTH);
  localparam int LP_ID_W = id_width(P_NUM_REQ);

  generate
    if ((P_DATA_WIDTH % 2) != 0) begin : g_bad_width
      $error("adder_share_sched: P_DATA_WIDTH must be even");
    end
    if (P_NUM_REQ < 2) begin : g_bad_num_req
      $error("adder_share_sched: P_NUM_REQ must be at least 2");
    end
  endgenerate

  // Stage-1 record: low-half sum with its carry in the MSB, plus the raw high
  // halves waiting for stage 2.
  typedef struct packed {
    logic               vld;
    logic [LP_ID_W-1:0] id;
    logic [LP_HALF:0]   lo;
    logic [LP_HALF-1:0] ahi;
    logic [LP_HALF-1:0] bhi;
  } s1_rec_t;

  logic [P_NUM_REQ-1:0]    gnt;
  logic [LP_ID_W-1:0]      gnt_id;
  logic [P_DATA_WIDTH-1:0] sel_a;
  logic [P_DATA_WIDTH-1:0] sel_b;
  logic                    sel_cin;
  logic [LP_HALF:0]        lo_sum;
  logic [LP_HALF:0]        hi_sum;
  s1_rec_t                 s1;
  logic                    vld_q;
  logic [LP_ID_W-1:0]      id_q;
  logic [P_DATA_WIDTH-1:0] sum_q;
  logic                    cout_q;

  rr_arbiter #(
    .P_NUM_REQ (P_NUM_REQ),
    .P_ID_W    (LP_ID_W)
  ) u_arb (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_req    (bus.i_req),
    .i_hold   (bus.i_hold),
    .o_gnt    (gnt),
    .o_gnt_id (gnt_id)
  );

  // Operand mux. With no grant gnt_id is 0 and requester 0's operands flow
  // into the data regs; s1.vld=0 marks that cycle as a bubble.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int k = 0; k < P_NUM_REQ; k++) begin
      if (gnt_id == LP_ID_W'(k)) begin
        sel_a   = bus.i_a[k*P_DATA_WIDTH +: P_DATA_WIDTH];
        sel_b   = bus.i_b[k*P_DATA_WIDTH +: P_DATA_WIDTH];
        sel_cin = bus.i_cin[k];
      end
    end
  end

  assign lo_sum = {1'b0, sel_a[LP_HALF-1:0]} + {1'b0, sel_b[LP_HALF-1:0]}
                + {{LP_HALF{1'b0}}, sel_cin};

  assign hi_sum = {1'b0, s1.ahi} + {1'b0, s1.bhi} + {{LP_HALF{1'b0}}, s1.lo[LP_HALF]};

  // Stage 1: capture on the grant edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1 <= '0;
    end else begin
      s1.vld <= |gnt;
      s1.id  <= gnt_id;
      s1.lo  <= lo_sum;
      s1.ahi <= sel_a[P_DATA_WIDTH-1:LP_HALF];
      s1.bhi <= sel_b[P_DATA_WIDTH-1:LP_HALF];
    end
  end

  // Stage 2: high half plus registered low carry; low half passes through.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_q  <= 1'b0;
      id_q   <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      vld_q                          <= s1.vld;
      id_q                           <= s1.id;
      sum_q[LP_HALF-1:0]             <= s1.lo[LP_HALF-1:0];
      sum_q[P_DATA_WIDTH-1:LP_HALF]  <= hi_sum[LP_HALF-1:0];
      cout_q                         <= hi_sum[LP_HALF];
    end
  end

  assign bus.o_gnt  = gnt;
  assign bus.o_vld  = vld_q;
  assign bus.o_id   = id_q;
  assign bus.o_sum  = sum_q;
  assign bus.o_cout = cout_q;

endmodule

// File: tb/tb_adder_share_sched.sv
// ---------------------------------------------------------------------------
// tb_adder_share_sched
// Directed and randomized bench for adder_share_sched (4 requesters, 6-bit).
// A behavioural model computes the expected grant from the arbitration rule
// and the expected result as the plain sum a+b+cin, delivered LP_LATENCY
// cycles after the grant. Honours ADDER_SCHED_PRIO_EN like the design.
// ---------------------------------------------------------------------------
module tb_adder_share_sched;
  import adder_sched_pkg::*;

  localparam int W    = 6;
  localparam int N    = 4;
  localparam int ID_W = 2;
  localparam int EW   = ID_W + 1 + W;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  logic [N-1:0]   req  = '0;
  logic [N*W-1:0] a    = '0;
  logic [N*W-1:0] b    = '0;
  logic [N-1:0]   cin  = '0;
  logic           hold = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  adder_share_sched_if #(.P_DATA_WIDTH(W), .P_NUM_REQ(N)) bus();

  assign bus.i_req  = req;
  assign bus.i_a    = a;
  assign bus.i_b    = b;
  assign bus.i_cin  = cin;
  assign bus.i_hold = hold;

  adder_share_sched #(.P_DATA_WIDTH(W), .P_NUM_REQ(N)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [N-1:0] model_grant(input logic [N-1:0] r, input logic h, input int p);
    logic [N-1:0] g;
    int k;
    g = '0;
    if (!h) begin
      for (int i = N - 1; i >= 0; i--) begin
        k = (p + i) % N;
        if (r[k]) g = '0;
        if (r[k]) g[k] = 1'b1;
      end
    end
    return g;
  endfunction

  logic [EW-1:0] exp_q[$];
  bit            mv[LP_LATENCY];
  int            m_ptr = 0;

  // Compare process: inputs are stable at the falling edge; registered
  // outputs reflect the previous rising edge. After checking, the model is
  // advanced as if the next rising edge happens.
  always @(negedge i_clk) begin
    logic [N-1:0]  eg;
    logic [EW-1:0] e;
    logic [W:0]    full;
    int            k;
    if (chk_en) begin
      eg = model_grant(req, hold, m_ptr);
      check("gnt", {28'd0, bus.o_gnt}, {28'd0, eg});
      if (i_rst) begin
        check("rst_vld", {31'd0, bus.o_vld}, 32'd0);
        check("rst_sum", {26'd0, bus.o_sum}, 32'd0);
        m_ptr = 0;
        for (int i = 0; i < LP_LATENCY; i++) mv[i] = 1'b0;
        exp_q.delete();
      end else begin
        check("vld", {31'd0, bus.o_vld}, {31'd0, mv[LP_LATENCY-1]});
        if (mv[LP_LATENCY-1]) begin
          if (exp_q.size() == 0) begin
            check("exp_q_underflow", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            if (bus.o_vld) begin
              check("id",   {30'd0, bus.o_id},   {30'd0, e[EW-1 -: ID_W]});
              check("cout", {31'd0, bus.o_cout}, {31'd0, e[W]});
              check("sum",  {26'd0, bus.o_sum},  {26'd0, e[W-1:0]});
            end
          end
        end
        for (int i = LP_LATENCY - 1; i > 0; i--) mv[i] = mv[i-1];
        mv[0] = |eg;
        if (|eg) begin
          k = 0;
          for (int i = 0; i < N; i++) if (eg[i]) k = i;
          full = {1'b0, a[k*W +: W]} + {1'b0, b[k*W +: W]} + (W+1)'(cin[k]);
          exp_q.push_back({ID_W'(k), full});
`ifndef ADDER_SCHED_PRIO_EN
          m_ptr = (k + 1) % N;
`endif
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_op(input int k, input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
    a[k*W +: W] = va;
    b[k*W +: W] = vb;
    cin[k]      = vc;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once and no
  // result may appear for two cycles afterwards.
  task automatic do_reset();
    @(posedge i_clk); #2;
    i_rst = 1'b1;
    req   = '0;
    hold  = 1'b0;
    #1;
    check("async_rst_vld",  {31'd0, bus.o_vld},  32'd0);
    check("async_rst_id",   {30'd0, bus.o_id},   32'd0);
    check("async_rst_sum",  {26'd0, bus.o_sum},  32'd0);
    check("async_rst_cout", {31'd0, bus.o_cout}, 32'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    repeat (2) begin
      @(negedge i_clk);
      check("post_rst_vld", {31'd0, bus.o_vld}, 32'd0);
    end
  endtask

  task automatic random_phase(input int cycles);
    logic [N-1:0] g_last;
    for (int c = 0; c < cycles; c++) begin
      @(negedge i_clk);
      g_last = bus.o_gnt;
      @(posedge i_clk); #1;
      for (int k = 0; k < N; k++) begin
        if (req[k] && g_last[k]) begin
          if ($urandom_range(0, 1) == 0) req[k] = 1'b0;
          else set_op(k, W'($urandom_range(0, 63)), W'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
        end else if (!req[k] && ($urandom_range(0, 9) < 4)) begin
          req[k] = 1'b1;
          set_op(k, W'($urandom_range(0, 63)), W'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
        end
      end
      hold = ($urandom_range(0, 7) == 0);
    end
    @(posedge i_clk); #1;
    req  = '0;
    hold = 1'b0;
    repeat (3) @(negedge i_clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    chk_en = 1'b1;
    do_reset();

    // Single op on requester 2: 0x2D + 0x1A + 1 = 0x48 -> sum 0x08, cout 1.
    @(posedge i_clk); #1;
    set_op(2, 6'h2D, 6'h1A, 1'b1);
    req = 4'b0100;
    @(negedge i_clk);
    check("single_gnt", {28'd0, bus.o_gnt}, 32'h4);
    @(posedge i_clk); #1;
    req = '0;
    @(negedge i_clk);
    check("single_vld_early", {31'd0, bus.o_vld}, 32'd0);
    @(negedge i_clk);
    check("single_vld",  {31'd0, bus.o_vld},  32'd1);
    check("single_id",   {30'd0, bus.o_id},   32'd2);
    check("single_sum",  {26'd0, bus.o_sum},  32'h08);
    check("single_cout", {31'd0, bus.o_cout}, 32'd1);

    // Reset with operations in flight.
    @(posedge i_clk); #1;
    req = 4'b1111;
    repeat (3) @(negedge i_clk);
    do_reset();

`ifndef ADDER_SCHED_PRIO_EN
    // Round-robin from pointer 0: grants 0,1,2,3,0,1,2,3; ids follow 2 later.
    @(posedge i_clk); #1;
    req = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      if (i < 8) check("rr_gnt", {28'd0, bus.o_gnt}, 32'd1 << (i % 4));
      if (i >= 2) begin
        check("rr_vld", {31'd0, bus.o_vld}, 32'd1);
        check("rr_id",  {30'd0, bus.o_id},  32'((i - 2) % 4));
      end
      if (i == 7) begin
        @(posedge i_clk); #1;
        req = '0;
      end
    end
`endif

    // Carry chain on requester 0, two back-to-back ops.
    @(posedge i_clk); #1;
    set_op(0, 6'h07, 6'h01, 1'b0);
    req = 4'b0001;
    @(negedge i_clk);
    check("carry_gnt", {28'd0, bus.o_gnt}, 32'h1);
    @(posedge i_clk); #1;
    set_op(0, 6'h3F, 6'h00, 1'b1);
    @(negedge i_clk);
    @(posedge i_clk); #1;
    req = '0;
    @(negedge i_clk);
    check("carry1_vld",  {31'd0, bus.o_vld},  32'd1);
    check("carry1_sum",  {26'd0, bus.o_sum},  32'h08);
    check("carry1_cout", {31'd0, bus.o_cout}, 32'd0);
    @(negedge i_clk);
    check("carry2_vld",  {31'd0, bus.o_vld},  32'd1);
    check("carry2_sum",  {26'd0, bus.o_sum},  32'h00);
    check("carry2_cout", {31'd0, bus.o_cout}, 32'd1);

`ifndef ADDER_SCHED_PRIO_EN
    // Hold: pointer is preserved across the held cycles.
    do_reset();
    @(posedge i_clk); #1;
    set_op(0, 6'h05, 6'h03, 1'b0);
    set_op(1, 6'h10, 6'h20, 1'b0);
    req = 4'b0011;
    @(negedge i_clk);
    check("hold_first_gnt", {28'd0, bus.o_gnt}, 32'h1);
    @(posedge i_clk); #1;
    req  = 4'b0010;
    hold = 1'b1;
    @(negedge i_clk);
    check("hold_gnt0", {28'd0, bus.o_gnt}, 32'd0);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check("hold_gnt1", {28'd0, bus.o_gnt}, 32'd0);
    check("hold_vld",  {31'd0, bus.o_vld}, 32'd1);
    check("hold_id",   {30'd0, bus.o_id},  32'd0);
    check("hold_sum",  {26'd0, bus.o_sum}, 32'h08);
    @(posedge i_clk); #1;
    hold = 1'b0;
    @(negedge i_clk);
    check("hold_release_gnt", {28'd0, bus.o_gnt}, 32'h2);
    @(posedge i_clk); #1;
    req = '0;
    repeat (3) @(negedge i_clk);
`else
    // Fixed priority: requester 1 always beats requester 3.
    do_reset();
    @(posedge i_clk); #1;
    set_op(1, 6'h01, 6'h02, 1'b0);
    set_op(3, 6'h04, 6'h08, 1'b0);
    req = 4'b1010;
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clk);
      check("prio_gnt", {28'd0, bus.o_gnt}, 32'h2);
      if (i >= 2) check("prio_id", {30'd0, bus.o_id}, 32'd1);
    end
    @(posedge i_clk); #1;
    req = '0;
    repeat (3) @(negedge i_clk);
`endif

    // Randomized traffic with a reset in the middle.
    random_phase(1500);
    do_reset();
    random_phase(1500);

    @(negedge i_clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
